fifo_wr_arbiter: RTL and testbench

Two-requester round-robin write arbiter that shares one FIFO write port between two producers.
- Each producer presents a word with a request/acknowledge handshake.
- The arbiter grants one producer at a time and forwards its words into the FIFO, subject to the FIFO full flag.
- Grants are held for bursts of at most MAX_BURST words, so neither producer can starve the other.
- Sits between the producer blocks and the FIFO's wr/wr_data/full interface.

---
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-requester round-robin arbiter sharing one FIFO write port.
//   clk, reset        : clock, synchronous active-high reset
//   req0/data0        : requester 0 word + valid (held until ack0)
//   req1/data1        : requester 1 word + valid (held until ack1)
//   full              : FIFO full flag
//   ack0/ack1         : single-cycle accept pulse per word
//   gnt0/gnt1         : requester currently holds the grant
//   wr/wr_data        : FIFO write strobe and data
//   cnt0/cnt1         : per-requester accepted-word counters (wrap)

// Per-requester accepted-word counter.
module fifo_wr_arbiter_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

module fifo_wr_arbiter #(
  parameter int B         = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [B-1:0]     data0,
  input  logic             req1,
  input  logic [B-1:0]     data1,
  input  logic             full,
  output logic             ack0,
  output logic             ack1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             wr,
  output logic [B-1:0]     wr_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;   // requester served most recently
  logic [BW-1:0] bcnt, bcnt_nxt;

  logic [1:0]            req_v, ack_v;
  logic [1:0][CNT_W-1:0] cnt_v;
  logic                  own;      // index of the current grant holder
  logic                  own_req, oth_req;
  state_t                oth_state;

  assign req_v = {req1, req0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;   // requester 0 wins the first tie
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    gnt0      = (state == GNT0);
    gnt1      = (state == GNT1);
    own       = gnt1;
    own_req   = req_v[own];
    oth_req   = req_v[~own];
    oth_state = own ? GNT0 : GNT1;
    wr        = ((gnt0 & req0) | (gnt1 & req1)) & ~full;
    ack0      = wr & gnt0;
    ack1      = wr & gnt1;
    wr_data   = gnt1 ? data1 : data0;

    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? GNT0 : GNT1;
        else if (req0)     state_nxt = GNT0;
        else if (req1)     state_nxt = GNT1;
      end
      default: begin
        if (!own_req) begin
          // Holder went away (even while full): hand over or go idle.
          last_nxt  = own;
          bcnt_nxt  = '0;
          state_nxt = oth_req ? oth_state : IDLE;
        end else if (wr) begin
          if (bcnt == LAST_BEAT) begin
            // Burst complete: yield only if the other side is waiting.
            bcnt_nxt = '0;
            if (oth_req) begin
              last_nxt  = own;
              state_nxt = oth_state;
            end
          end else begin
            bcnt_nxt = bcnt + 1'b1;
          end
        end
        // full with req held: everything holds.
      end
    endcase
  end

  assign ack_v = {ack1, ack0};

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    fifo_wr_arbiter_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ack_v[i]),
      .cnt   (cnt_v[i])
    );
  end

  assign cnt0 = cnt_v[0];
  assign cnt1 = cnt_v[1];
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers,
// with a per-cycle reference model of grant ownership and word counts.
module tb_fifo_wr_arbiter;
  localparam int MAXB = 4;

  logic        clk = 0;
  logic        reset = 0;
  logic        req0 = 0, req1 = 0, full = 0;
  logic [7:0]  data0 = 0, data1 = 0;
  logic        ack0, ack1, gnt0, gnt1, wr;
  logic [7:0]  wr_data;
  logic [15:0] cnt0, cnt1;

  fifo_wr_arbiter #(.B(8), .MAX_BURST(MAXB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1), .full(full),
    .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1),
    .wr(wr), .wr_data(wr_data), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Producer knobs (percent).
  int   raise0 = 0, raise1 = 0, keep0 = 0, keep1 = 0, pfull = 0;
  bit   rst_next = 0;
  bit   use_fix0 = 0;
  logic a0_seen = 0, a1_seen = 0;

  // Reference model: who owns the port, who was served last, words in burst.
  int          m_own = -1;
  int          m_last = 1;
  int          m_burst = 0;
  logic [15:0] m_cnt0 = 0, m_cnt1 = 0;
  bit          m_ok = 0;
  logic        e_wr;
  logic        rq [2];

  always @(negedge clk) begin
    a0_seen = ack0;
    a1_seen = ack1;
    rq[0] = req0;
    rq[1] = req1;
    e_wr = (m_own >= 0) && rq[(m_own >= 0) ? m_own : 0] && !full;
    if (m_ok) begin
      chk("gnt0",    gnt0, m_own == 0);
      chk("gnt1",    gnt1, m_own == 1);
      chk("wr",      wr, e_wr);
      chk("ack0",    ack0, e_wr && m_own == 0);
      chk("ack1",    ack1, e_wr && m_own == 1);
      chk("wr_data", wr_data, (m_own == 1) ? data1 : data0);
      chk("cnt0",    cnt0, m_cnt0);
      chk("cnt1",    cnt1, m_cnt1);
      chk("one_ack", ack0 & ack1, 0);
    end
    if (reset) begin
      m_own = -1; m_last = 1; m_burst = 0; m_cnt0 = 0; m_cnt1 = 0; m_ok = 1;
    end else if (m_ok) begin
      if (e_wr && m_own == 0) m_cnt0 = m_cnt0 + 1;
      if (e_wr && m_own == 1) m_cnt1 = m_cnt1 + 1;
      if (m_own < 0) begin
        if (rq[0] && rq[1]) m_own = 1 - m_last;
        else if (rq[0])     m_own = 0;
        else if (rq[1])     m_own = 1;
      end else begin
        int x, o;
        bit rel;
        x = m_own; o = 1 - x; rel = 0;
        if (!rq[x]) rel = 1;
        else if (e_wr) begin
          m_burst++;
          if (m_burst == MAXB) begin
            m_burst = 0;
            if (rq[o]) rel = 1;
          end
        end
        if (rel) begin
          m_last = x; m_burst = 0;
          m_own = rq[o] ? o : -1;
        end
      end
    end
  end

  // One clock: inputs move 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk); #1;
    reset = rst_next;
    if (rst_next) begin
      req0 = 0; req1 = 0;
    end else begin
      if (req0) begin
        if (a0_seen) begin
          data0 = 8'($urandom);
          if ($urandom_range(99) >= keep0) req0 = 0;
        end
      end else if ($urandom_range(99) < raise0) begin
        req0 = 1;
        data0 = use_fix0 ? 8'hA1 : 8'($urandom);
      end
      if (req1) begin
        if (a1_seen) begin
          data1 = 8'($urandom);
          if ($urandom_range(99) >= keep1) req1 = 0;
        end
      end else if ($urandom_range(99) < raise1) begin
        req1 = 1;
        data1 = 8'($urandom);
      end
    end
    full = ($urandom_range(99) < pfull);
  endtask

  task automatic reset_dut();
    raise0 = 0; raise1 = 0; keep0 = 0; keep1 = 0; pfull = 0;
    rst_next = 1;
    cycle(); cycle();
    rst_next = 0;
    cycle();
  endtask

  initial begin
    // 1: single word after reset.
    reset_dut();
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_wr",   wr, 0);
    chk("rst_cnt0", cnt0, 0);
    use_fix0 = 1; raise0 = 100; keep0 = 0;
    cycle();
    raise0 = 0; use_fix0 = 0;
    cycle();
    @(negedge clk);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_ack0", ack0, 1);
    chk("t1_data", wr_data, 8'hA1);
    cycle();
    @(negedge clk);
    chk("t1_cnt0", cnt0, 1);
    cycle();
    chk("t1_mdl_cnt0", m_cnt0, 1);

    // 2: both held -> bursts of 4 alternating, requester 0 first.
    reset_dut();
    raise0 = 100; raise1 = 100; keep0 = 100; keep1 = 100;
    cycle(); cycle();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t2_ack0", ack0, ((i / 4) % 2) == 0);
      chk("t2_ack1", ack1, ((i / 4) % 2) == 1);
      cycle();
    end
    @(negedge clk);
    chk("t2_cnt0", cnt0, 8);
    chk("t2_cnt1", cnt1, 8);

    // 3: lone requester 1 keeps the grant across burst boundaries.
    reset_dut();
    raise1 = 100; keep1 = 100;
    cycle();
    raise1 = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_gnt1", gnt1, 1);
      chk("t3_ack1", ack1, 1);
      if (i == 9) keep1 = 0;
      cycle();
    end
    @(negedge clk);
    chk("t3_cnt1", cnt1, 10);

    // 4: full stall mid-burst; burst position survives the stall.
    reset_dut();
    raise0 = 100; keep0 = 100;
    cycle();
    raise0 = 0;
    cycle();
    @(negedge clk); chk("t4_ack0_a", ack0, 1);
    cycle();
    @(negedge clk); chk("t4_ack0_b", ack0, 1);
    pfull = 100; raise1 = 100; keep1 = 100;
    cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_gnt0", gnt0, 1);
      chk("t4_stall_wr",   wr, 0);
      chk("t4_stall_ack0", ack0, 0);
      if (k == 2) pfull = 0;
      cycle();
    end
    @(negedge clk); chk("t4_ack0_c", ack0, 1);
    cycle();
    @(negedge clk); chk("t4_ack0_d", ack0, 1);
    cycle();
    @(negedge clk);
    chk("t4_gnt1", gnt1, 1);
    chk("t4_ack1", ack1, 1);

    // 5: requester 0 leaves after 2 words while 1 waits.
    reset_dut();
    raise0 = 100; raise1 = 100; keep0 = 100; keep1 = 100;
    cycle();
    raise0 = 0; raise1 = 0;
    cycle();
    @(negedge clk); chk("t5_ack0_a", ack0, 1);
    cycle();
    @(negedge clk); chk("t5_ack0_b", ack0, 1);
    keep0 = 0;
    cycle();
    @(negedge clk);
    chk("t5_drop_gnt0", gnt0, 1);
    chk("t5_drop_wr",   wr, 0);
    cycle();
    @(negedge clk);
    chk("t5_gnt1", gnt1, 1);
    chk("t5_ack1", ack1, 1);

    // 6: reset in the middle of a requester 1 burst.
    reset_dut();
    raise1 = 100; keep1 = 100;
    cycle(); cycle();
    @(negedge clk); chk("t6_ack1_a", ack1, 1);
    cycle();
    @(negedge clk); chk("t6_ack1_b", ack1, 1);
    raise0 = 100; keep0 = 100;
    rst_next = 1;
    cycle();
    rst_next = 0;
    cycle();
    @(negedge clk);
    chk("t6_gnt1", gnt1, 0);
    chk("t6_ack1", ack1, 0);
    chk("t6_cnt1", cnt1, 0);
    cycle();
    @(negedge clk);
    chk("t6_tie_gnt0", gnt0, 1);
    chk("t6_tie_ack0", ack0, 1);

    // Random traffic, full pressure and occasional resets.
    reset_dut();
    raise0 = 60; raise1 = 60; keep0 = 70; keep1 = 70; pfull = 25;
    for (int n = 0; n < 4000; n++) begin
      rst_next = ($urandom_range(199) == 0);
      cycle();
    end
    rst_next = 0;
    cycle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
